// File: rtl/sram_ctrl.sv
// Asynchronous SRAM access controller.
// Each access runs SETUP -> STROBE (WAIT cycles) -> HOLD -> DONE. The controller
// keeps an auto-incrementing address register. The SRAM strobes and the
// data-bus enable are registered from the next state, so the pins change
// cleanly on clock edges.
module sram_ctrl #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 19,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic              addr_ld,
    input  logic [AWIDTH-1:0] addr_in,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic [AWIDTH-1:0] sram_addr,
    inout  wire  [DWIDTH-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    // A strobe shorter than one cycle is meaningless, so clamp it to one.
    localparam int WAIT_EFF = (WAIT < 1) ? 1 : WAIT;
    localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              drive_q, drive_d;
    logic              active_d;

    // Next-state, datapath updates and registered pin values derived from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                // The address load takes effect at the same edge, so a
                // simultaneous request uses the freshly loaded address.
                if (addr_ld) begin
                    addr_d = addr_in;
                end
                if (req) begin
                    wr_d    = wr;
                    wdata_d = wdata;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_HOLD;
                    if (!wr_q) begin
                        rdata_d = sram_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                addr_d  = addr_q + AWIDTH'(1);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        ce_n_d   = !active_d;
        oe_n_d   = !((state_d == S_STROBE) && !wr_d);
        we_n_d   = !((state_d == S_STROBE) && wr_d);
        drive_d  = active_d && wr_d;
    end

    // Control, address and read-data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            drive_q <= drive_d;
        end
    end

    // Write data latch; only ever observed on the bus when drive_q is set.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    assign sram_data = drive_q ? wdata_q : {DWIDTH{1'bz}};
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign rdata     = rdata_q;
    assign ack       = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural SRAM on the bus.
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic        addr_ld;
    logic [18:0] addr_in;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        busy;
    logic [18:0] sram_addr;
    tri   [7:0]  sram_data;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int total = 0;
    int bad   = 0;

    sram_ctrl #(.DWIDTH(8), .AWIDTH(19), .WAIT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wr        (wr),
        .addr_ld   (addr_ld),
        .addr_in   (addr_in),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .busy      (busy),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: 4K window on the low address bits, plus a preload port.
    logic [7:0]  mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_a  = '0;
    logic [7:0]  pl_d  = '0;

    assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[11:0]] : 8'hzz;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_a] <= pl_d;
        else if (!sram_ce_n && !sram_we_n)
            mem[sram_addr[11:0]] <= sram_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Bus-protocol monitor: strobes never overlap; the controller never drives during a read or when deselected.
    logic mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("oe_we_overlap", {31'd0, (!sram_oe_n && !sram_we_n)}, 32'd0);
            if (!sram_oe_n || sram_ce_n)
                chk("bus_hiz", {31'd0, dut.drive_q}, 32'd0);
        end
    end

    // Results of one access.
    int          r_we, r_oe, r_ack_at;
    logic [18:0] r_addr;
    logic        r_bus_ok;

    task automatic access(input logic w, input logic [7:0] d, input logic ld,
                          input logic [18:0] la, input logic ld_busy);
        r_we = 0; r_oe = 0; r_ack_at = 0; r_addr = '1; r_bus_ok = 1'b1;
        req = 1'b1; wr = w; wdata = d; addr_ld = ld; addr_in = la;
        tick();
        // Scramble inputs while busy: the access must not be affected.
        req = 1'b0; wr = ~w; wdata = ~d; addr_ld = ld_busy; addr_in = 19'h2_2222;
        for (int k = 1; k <= 12 && r_ack_at == 0; k++) begin
            if (!sram_we_n) begin
                r_we++;
                r_addr = sram_addr;
                if (sram_data !== d) r_bus_ok = 1'b0;
            end
            if (!sram_oe_n) begin
                r_oe++;
                r_addr = sram_addr;
            end
            if (ack) r_ack_at = k;
            tick();
        end
        addr_ld = 1'b0;
    endtask

    int          acks, gaps, ai, late_acks;
    logic        prev_oe;
    logic [18:0] oa [0:2];
    logic [7:0]  rd [0:2];

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr_ld = 1'b0; addr_in = '0; wdata = '0;
        tick();
        tick();
        mon_en = 1'b1;
        // Reset state
        chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {13'd0, sram_addr}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        rst_n = 1'b1;

        // Write 0xA5 at 0x00010; addr_ld pulsed while busy must be ignored
        addr_ld = 1'b1; addr_in = 19'h00010;
        tick();
        addr_ld = 1'b0;
        chk("ld_addr", {13'd0, sram_addr}, 32'h10);
        access(1'b1, 8'hA5, 1'b0, 19'h0, 1'b1);
        chk("w1_we_cycles", r_we, 2);
        chk("w1_oe_cycles", r_oe, 0);
        chk("w1_ack_edge", r_ack_at, 5);
        chk("w1_strobe_addr", {13'd0, r_addr}, 32'h10);
        chk("w1_bus_data", {31'd0, r_bus_ok}, 32'd1);
        chk("w1_addr_inc", {13'd0, sram_addr}, 32'h11);
        chk("w1_mem", {24'd0, mem[12'h010]}, 32'hA5);
        chk("w1_idle_ack", {31'd0, ack}, 32'd0);
        chk("w1_idle_busy", {31'd0, busy}, 32'd0);

        // Read 0x3C from 0x00011
        preload(12'h011, 8'h3C);
        access(1'b0, 8'h00, 1'b0, 19'h0, 1'b0);
        chk("r1_oe_cycles", r_oe, 2);
        chk("r1_we_cycles", r_we, 0);
        chk("r1_ack_edge", r_ack_at, 5);
        chk("r1_strobe_addr", {13'd0, r_addr}, 32'h11);
        chk("r1_rdata", {24'd0, rdata}, 32'h3C);
        chk("r1_addr_inc", {13'd0, sram_addr}, 32'h12);

        // Address wrap: write at 0x7FFFF, then read at 0x00000
        access(1'b1, 8'h11, 1'b1, 19'h7FFFF, 1'b0);
        chk("wrap_strobe_addr", {13'd0, r_addr}, 32'h7FFFF);
        chk("wrap_ack_edge", r_ack_at, 5);
        chk("wrap_addr", {13'd0, sram_addr}, 32'h0);
        chk("wrap_mem", {24'd0, mem[12'hFFF]}, 32'h11);
        preload(12'h000, 8'h5A);
        access(1'b0, 8'h00, 1'b0, 19'h0, 1'b0);
        chk("wrap_rd_addr", {13'd0, r_addr}, 32'h0);
        chk("wrap_rdata", {24'd0, rdata}, 32'h5A);

        // req held high: three back-to-back reads at 1, 2, 3
        preload(12'h001, 8'h21);
        preload(12'h002, 8'h22);
        preload(12'h003, 8'h23);
        req = 1'b1; wr = 1'b0;
        acks = 0; gaps = 0; ai = 0; prev_oe = 1'b1;
        for (int k = 0; k < 30 && acks < 3; k++) begin
            tick();
            if (!sram_oe_n && prev_oe && ai < 3) begin
                oa[ai] = sram_addr;
                ai++;
            end
            prev_oe = sram_oe_n;
            if (ack) begin
                rd[acks] = rdata;
                acks++;
                if (acks == 3) req = 1'b0;
            end else if (!busy && acks >= 1) begin
                gaps++;
            end
        end
        chk("held_acks", acks, 3);
        chk("held_gaps", gaps, 2);
        chk("held_addr0", {13'd0, oa[0]}, 32'h1);
        chk("held_addr1", {13'd0, oa[1]}, 32'h2);
        chk("held_addr2", {13'd0, oa[2]}, 32'h3);
        chk("held_rd0", {24'd0, rd[0]}, 32'h21);
        chk("held_rd1", {24'd0, rd[1]}, 32'h22);
        chk("held_rd2", {24'd0, rd[2]}, 32'h23);
        tick();
        chk("held_stop_busy", {31'd0, busy}, 32'd0);
        chk("held_next_addr", {13'd0, sram_addr}, 32'h4);

        // Reset during the second STROBE cycle of a write
        req = 1'b1; wr = 1'b1; wdata = 8'h77;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("mid_we_low", {31'd0, sram_we_n}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("mid_rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("mid_rst_drive", {31'd0, dut.drive_q}, 32'd0);
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_addr", {13'd0, sram_addr}, 32'h0);
        chk("mid_rst_rdata", {24'd0, rdata}, 32'h0);
        rst_n = 1'b1;
        late_acks = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ack) late_acks++;
        end
        chk("mid_rst_no_ack", late_acks, 0);

        // addr_ld with req in the same IDLE cycle; addr_ld while busy ignored
        access(1'b1, 8'hC3, 1'b1, 19'h00100, 1'b1);
        chk("ld_req_addr", {13'd0, r_addr}, 32'h100);
        chk("ld_req_we_cycles", r_we, 2);
        chk("ld_req_ack_edge", r_ack_at, 5);
        chk("ld_req_bus", {31'd0, r_bus_ok}, 32'd1);
        chk("ld_busy_ignored", {13'd0, sram_addr}, 32'h101);
        chk("ld_req_mem", {24'd0, mem[12'h100]}, 32'hC3);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
